// File: rtl/sprite_streamer_pkg.sv
// Shared types and constants for the sprite streamer.
// Optional build macro: SPRITE_SCALE2_EN (emit each bitmap pixel as a 2x2 block).
package sprite_pkg;

    localparam int SPRITE_SIZE = 25;
    localparam int XW          = 10;
    localparam int YW          = 9;
    localparam int CW          = 12;

`ifdef SPRITE_SCALE2_EN
    localparam int SCALE       = 2;
    localparam int SCALE_SHIFT = 1;
`else
    localparam int SCALE       = 1;
    localparam int SCALE_SHIFT = 0;
`endif

    // Output raster edge length and the counter width that covers it
    localparam int OUT_SIZE = SPRITE_SIZE * SCALE;
    localparam int CNT_W    = 6;

    typedef logic [SPRITE_SIZE-1:0] bitmap_t [0:SPRITE_SIZE-1];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // A 0 bit is ink, a 1 bit is paper
    function automatic logic [CW-1:0] pick_color(input logic          bit_val,
                                                 input logic [CW-1:0] ink,
                                                 input logic [CW-1:0] paper);
        logic [CW-1:0] c;
        if (bit_val == 1'b0) c = ink;
        else                 c = paper;
        return c;
    endfunction

endpackage

// File: rtl/sprite_streamer_if.sv
// Pixel-write stream between the sprite streamer and the frame-buffer writer.
interface sprite_streamer_if;
    import sprite_pkg::*;

    logic          pix_valid;
    logic          pix_ready;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [CW-1:0] pix_color;
    logic          pix_last;

    modport master (
        output pix_valid, pix_x, pix_y, pix_color, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/sprite_streamer_addr_gen.sv
// Raster address generator: (u, v) points at the next output pixel to be
// loaded into the output registers; wraps row-major over the output raster.
module sprite_addr_gen
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] u,
    output logic [CNT_W-1:0] v,
    output logic             is_last
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_SIZE - 1);

    logic [CNT_W-1:0] u_r;
    logic [CNT_W-1:0] v_r;

    // Column counter steps every advance, row counter steps at end of line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_r <= '0;
            v_r <= '0;
        end else if (clear) begin
            u_r <= '0;
            v_r <= '0;
        end else if (advance) begin
            if (u_r == LAST_IDX) begin
                u_r <= '0;
                if (v_r == LAST_IDX) v_r <= '0;
                else                 v_r <= v_r + CNT_W'(1);
            end else begin
                u_r <= u_r + CNT_W'(1);
            end
        end
    end

    assign u       = u_r;
    assign v       = v_r;
    assign is_last = (u_r == LAST_IDX) && (v_r == LAST_IDX);

endmodule

// File: rtl/sprite_streamer.sv
// Streams a snapshotted 25x25 one-bit bitmap as coloured screen pixel writes.
// Optional build macro: SPRITE_SCALE2_EN (2x2 pixel replication).
// One launch cycle after start fills the output registers with pixel (0,0).
module sprite_streamer
    import sprite_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  bitmap_t       ishapes,
    input  logic          start,
    input  logic [XW-1:0] org_x,
    input  logic [YW-1:0] org_y,
    input  logic [CW-1:0] ink_color,
    input  logic [CW-1:0] paper_color,
    output logic          busy,
    output logic          done,
    sprite_streamer_if.master pix
);

    state_t           state_r;
    logic             launch_r;
    bitmap_t          snap_r;
    logic [XW-1:0]    org_x_r;
    logic [YW-1:0]    org_y_r;
    logic [CW-1:0]    ink_r;
    logic [CW-1:0]    paper_r;

    logic [CNT_W-1:0] u_s;
    logic [CNT_W-1:0] v_s;
    logic             is_last_s;
    logic             clear_s;
    logic             advance_s;
    logic             xfer_s;
    logic [4:0]       row_s;
    logic [4:0]       col_s;
    logic [4:0]       bit_idx_s;
    logic             bit_s;
    logic [XW-1:0]    next_x_s;
    logic [YW-1:0]    next_y_s;
    logic [CW-1:0]    next_color_s;

    sprite_addr_gen u_addr_gen (
        .clk     (clk),
        .rst     (reset),
        .clear   (clear_s),
        .advance (advance_s),
        .u       (u_s),
        .v       (v_s),
        .is_last (is_last_s)
    );

    // Counter control and the pixel word that the next load will present
    always_comb begin
        clear_s   = 1'b0;
        advance_s = 1'b0;
        xfer_s    = pix.pix_valid & pix.pix_ready;
        case (state_r)
            S_IDLE: begin
                if (launch_r)   advance_s = 1'b1;
                else if (start) clear_s   = 1'b1;
                else            clear_s   = 1'b0;
            end
            S_STREAM: begin
                if (xfer_s && !pix.pix_last) advance_s = 1'b1;
                else                         advance_s = 1'b0;
            end
            S_DONE:  advance_s = 1'b0;
            default: advance_s = 1'b0;
        endcase
        row_s        = 5'(v_s >> SCALE_SHIFT);
        col_s        = 5'(u_s >> SCALE_SHIFT);
        bit_idx_s    = 5'(SPRITE_SIZE - 1) - col_s;
        bit_s        = snap_r[row_s][bit_idx_s];
        next_x_s     = org_x_r + XW'(u_s);
        next_y_s     = org_y_r + YW'(v_s);
        next_color_s = pick_color(bit_s, ink_r, paper_r);
    end

    // Control FSM with snapshot and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= S_IDLE;
            launch_r      <= 1'b0;
            for (int r = 0; r < SPRITE_SIZE; r++) snap_r[r] <= '0;
            org_x_r       <= '0;
            org_y_r       <= '0;
            ink_r         <= '0;
            paper_r       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pix.pix_valid <= 1'b0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.pix_color <= '0;
            pix.pix_last  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (launch_r) begin
                        launch_r      <= 1'b0;
                        state_r       <= S_STREAM;
                        busy          <= 1'b1;
                        pix.pix_valid <= 1'b1;
                        pix.pix_x     <= next_x_s;
                        pix.pix_y     <= next_y_s;
                        pix.pix_color <= next_color_s;
                        pix.pix_last  <= is_last_s;
                    end else if (start) begin
                        launch_r <= 1'b1;
                        snap_r   <= ishapes;
                        org_x_r  <= org_x;
                        org_y_r  <= org_y;
                        ink_r    <= ink_color;
                        paper_r  <= paper_color;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (xfer_s && pix.pix_last) begin
                        state_r       <= S_DONE;
                        done          <= 1'b1;
                        pix.pix_valid <= 1'b0;
                        pix.pix_x     <= '0;
                        pix.pix_y     <= '0;
                        pix.pix_color <= '0;
                        pix.pix_last  <= 1'b0;
                    end else if (xfer_s) begin
                        pix.pix_x     <= next_x_s;
                        pix.pix_y     <= next_y_s;
                        pix.pix_color <= next_color_s;
                        pix.pix_last  <= is_last_s;
                    end else begin
                        pix.pix_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r       <= S_IDLE;
                    launch_r      <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    pix.pix_valid <= 1'b0;
                    pix.pix_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_streamer.sv
// Self-checking bench for sprite_streamer: table of stream scenarios checked
// pixel-by-pixel through a scoreboard queue, plus reset sequences.
module tb_sprite_streamer;
    import sprite_pkg::*;

`ifdef SPRITE_SCALE2_EN
    localparam int SC = 2;
`else
    localparam int SC = 1;
`endif
    localparam int OUT  = SPRITE_SIZE * SC;
    localparam int NPIX = OUT * OUT;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    bitmap_t       ishapes;
    logic [9:0]    org_x = 10'd0;
    logic [8:0]    org_y = 9'd0;
    logic [11:0]   ink_color = 12'h000;
    logic [11:0]   paper_color = 12'h000;
    logic          busy;
    logic          done;

    sprite_streamer_if pix ();

    sprite_streamer dut (
        .clk         (clk),
        .reset       (reset),
        .ishapes     (ishapes),
        .start       (start),
        .org_x       (org_x),
        .org_y       (org_y),
        .ink_color   (ink_color),
        .paper_color (paper_color),
        .busy        (busy),
        .done        (done),
        .pix         (pix)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [11:0] color;
        logic        last;
    } pix_t;

    typedef struct {
        int          kind;
        int          ox;
        int          oy;
        logic [11:0] ink;
        logic [11:0] paper;
        int          ready_mode;
        bit          disturb;
        logic [11:0] exp_first;
        logic [11:0] exp_second;
        int          exp_last_x;
        int          exp_last_y;
    } vec_t;

    pix_t    exp_q[$];
    bitmap_t model_bm;
    int      n_cmp = 0;
    int      n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pattern_bit(input int kind, input int r, input int c);
        case (kind)
            0:       return 1'b1;
            1:       return ((r + c) % 2) == 1;
            2:       return ((c % 3) == 0) ^ ((r % 2) == 1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic load_bitmap(input int kind);
        for (int r = 0; r < SPRITE_SIZE; r++)
            for (int c = 0; c < SPRITE_SIZE; c++) begin
                ishapes[r][SPRITE_SIZE-1-c]  = pattern_bit(kind, r, c);
                model_bm[r][SPRITE_SIZE-1-c] = pattern_bit(kind, r, c);
            end
    endtask

    // Reference raster for the current snapshot
    task automatic push_expected(input int ox, input int oy, input logic [11:0] ink, input logic [11:0] paper);
        pix_t e;
        for (int v = 0; v < OUT; v++)
            for (int u = 0; u < OUT; u++) begin
                e.x     = 10'((ox + u) % 1024);
                e.y     = 9'((oy + v) % 512);
                e.color = model_bm[v / SC][SPRITE_SIZE - 1 - (u / SC)] ? paper : ink;
                e.last  = (u == OUT - 1) && (v == OUT - 1);
                exp_q.push_back(e);
            end
    endtask

    function automatic pix_t cur_pix();
        pix_t p;
        p.x = pix.pix_x; p.y = pix.pix_y; p.color = pix.pix_color; p.last = pix.pix_last;
        return p;
    endfunction

    task automatic run_vec(input string name, input vec_t tv);
        int first_valid = -1, last_cyc = -1, done_cyc = -1, stalls = 0, done_cnt = 0, n_xfer = 0;
        logic [11:0] got_first = 12'h000, got_second = 12'h000;
        int got_lx = -1, got_ly = -1;
        bit stalled = 1'b0;
        pix_t held, cur, e;

        exp_q.delete();
        @(negedge clk);
        load_bitmap(tv.kind);
        org_x = 10'(tv.ox); org_y = 9'(tv.oy);
        ink_color = tv.ink; paper_color = tv.paper;
        push_expected(tv.ox, tv.oy, tv.ink, tv.paper);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4 * NPIX + 50; c++) begin
            case (tv.ready_mode)
                0:       pix.pix_ready = 1'b1;
                1:       pix.pix_ready = !((c % 4) == 1 || (c % 4) == 2);
                default: pix.pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (tv.disturb && c == 100) begin
                start = 1'b1;
                for (int r = 0; r < SPRITE_SIZE; r++) ishapes[r] = '0;
                org_x = 10'd0; org_y = 9'd0; ink_color = 12'hFFF; paper_color = 12'h000;
            end
            if (tv.disturb && c == 101) start = 1'b0;
            if (c == 0) check({name, "_launch_idle"}, {30'd0, busy, pix.pix_valid}, 32'd0);
            if (c == 1) check({name, "_busy_valid"}, {30'd0, busy, pix.pix_valid}, 32'd3);
            cur = cur_pix();
            if (pix.pix_valid) begin
                if (first_valid < 0) first_valid = c;
                if (stalled) check({name, "_hold"}, cur, held);
                if (pix.pix_ready) begin
                    if (exp_q.size() == 0) begin
                        check({name, "_extra_pixel"}, cur, 32'hFFFFFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check({name, "_pixel"}, cur, e);
                    end
                    if (n_xfer == 0) got_first = cur.color;
                    if (n_xfer == 1) got_second = cur.color;
                    if (cur.last) begin
                        last_cyc = c; got_lx = int'(cur.x); got_ly = int'(cur.y);
                    end
                    n_xfer++;
                    stalled = 1'b0;
                end else begin
                    stalls++;
                    stalled = 1'b1;
                    held = cur;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                check({name, "_idle_after_done"}, {30'd0, busy, done}, 32'd0);
                break;
            end
            @(negedge clk);
        end
        pix.pix_ready = 1'b0;
        if (done_cyc < 0) $display("FAIL %s_timeout: got no done pulse expected one", name);
        check({name, "_first_valid_cyc"}, 32'(first_valid), 32'd1);
        check({name, "_transfers"}, 32'(n_xfer), 32'(NPIX));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_last_cyc"}, 32'(last_cyc), 32'(NPIX + stalls));
        check({name, "_done_cyc"}, 32'(done_cyc), 32'(last_cyc + 1));
        check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({name, "_first_color"}, {20'd0, got_first}, {20'd0, tv.exp_first});
        check({name, "_second_color"}, {20'd0, got_second}, {20'd0, tv.exp_second});
        check({name, "_last_x"}, 32'(got_lx), 32'(tv.exp_last_x));
        check({name, "_last_y"}, 32'(got_ly), 32'(tv.exp_last_y));
        exp_q.delete();
    endtask

    vec_t vecs[5];

    initial begin
        int cnt;
        pix.pix_ready = 1'b0;
        for (int r = 0; r < SPRITE_SIZE; r++) ishapes[r] = '0;

        vecs[0] = '{0, 100, 50, 12'h00F, 12'hABC, 0, 1'b0, 12'hABC, 12'hABC, 100 + OUT - 1, 50 + OUT - 1};
        vecs[1] = '{1, 0, 0, 12'hF00, 12'h0FF, 0, 1'b0, 12'hF00, (SC == 1) ? 12'h0FF : 12'hF00, OUT - 1, OUT - 1};
        vecs[2] = '{2, 300, 200, 12'h123, 12'h456, 1, 1'b0, 12'h456, (SC == 1) ? 12'h123 : 12'h456, 300 + OUT - 1, 200 + OUT - 1};
        vecs[3] = '{1, 1015, 500, 12'h0F0, 12'h00F, 2, 1'b0, 12'h0F0, (SC == 1) ? 12'h00F : 12'h0F0, (1015 + OUT - 1) % 1024, (500 + OUT - 1) % 512};
        vecs[4] = '{0, 7, 9, 12'h111, 12'h222, 1, 1'b1, 12'h222, 12'h222, 7 + OUT - 1, 9 + OUT - 1};

        // Reset state
        #2;
        check("reset_state", {busy, done, pix.pix_valid, pix.pix_last, pix.pix_x, pix.pix_y, pix.pix_color},
              32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of a stream
        @(negedge clk);
        load_bitmap(0);
        org_x = 10'd100; org_y = 9'd50; ink_color = 12'h00F; paper_color = 12'hABC;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pix.pix_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 2 * NPIX && cnt < 300; c++) begin
            if (pix.pix_valid) cnt++;
            if (cnt < 300) @(negedge clk);
        end
        check("mid_reset_reached", 32'(cnt), 32'd300);
        reset = 1'b1;
        #1;
        check("mid_reset_outputs", {busy, done, pix.pix_valid, pix.pix_last, pix.pix_x, pix.pix_y, pix.pix_color},
              32'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || busy || pix.pix_valid) cnt++;
        end
        check("post_reset_quiet", 32'(cnt), 32'd0);
        pix.pix_ready = 1'b0;
        run_vec("after_reset", vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
